// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix sequencer and its datapath.
package matrix_pkg;

    // Default geometry and memory map
    localparam int unsigned DEF_ELEM_W  = 8;
    localparam int unsigned DEF_N_ELEM  = 25;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_RD_LAT  = 2;
    localparam int unsigned DEF_ALU_LAT = 1;
    localparam int unsigned DEF_BASE_A  = 0;
    localparam int unsigned DEF_BASE_B  = 32;
    localparam int unsigned DEF_BASE_C  = 64;

    // Datapath operation codes
    localparam int unsigned OP_W = 3;
    localparam logic [OP_W-1:0] OP_ADD    = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL    = 3'd2;
    localparam logic [OP_W-1:0] OP_TRANSP = 3'd3;
    localparam logic [OP_W-1:0] OP_SCALE  = 3'd4;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WR_C = 3'd4,
        FIN  = 3'd5
    } state_t;

    // Bits needed to index n items, never less than one
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift pipe of {valid, index} tags that follows RAM reads through the read latency.
module rd_tag_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Advance tags one stage per cycle; async clear drops all in-flight reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            idx_q[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Sequencer: loads A and B from RAM, waits on the datapath, writes C back, pulses done.
module matrix_seq_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned ELEM_W  = DEF_ELEM_W,
    parameter int unsigned N_ELEM  = DEF_N_ELEM,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned RD_LAT  = DEF_RD_LAT,
    parameter int unsigned ALU_LAT = DEF_ALU_LAT,
    parameter int unsigned BASE_A  = DEF_BASE_A,
    parameter int unsigned BASE_B  = DEF_BASE_B,
    parameter int unsigned BASE_C  = DEF_BASE_C
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [OP_W-1:0]          op,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [ELEM_W-1:0]        ram_wdata,
    output logic                     ram_we,
    input  logic [ELEM_W-1:0]        ram_rdata,
    output logic [N_ELEM*ELEM_W-1:0] mat_a,
    output logic [N_ELEM*ELEM_W-1:0] mat_b,
    output logic [OP_W-1:0]          alu_op,
    input  logic [N_ELEM*ELEM_W-1:0] mat_c
);

    localparam int unsigned MAT_W = N_ELEM * ELEM_W;
    localparam int unsigned IDX_W = idx_width(N_ELEM);
    localparam int unsigned CNT_W = idx_width(N_ELEM + RD_LAT + ALU_LAT + 1);
    localparam int unsigned SEL_W = idx_width(MAT_W);

    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(N_ELEM + RD_LAT - 1);
    localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(N_ELEM - 1);

    localparam longint unsigned ADDR_SPAN = 64'(1) << ADDR_W;

    // Every matrix must fit below 2**ADDR_W; the address counter never wraps
    if ((64'(BASE_A) + 64'(N_ELEM) > ADDR_SPAN) ||
        (64'(BASE_B) + 64'(N_ELEM) > ADDR_SPAN) ||
        (64'(BASE_C) + 64'(N_ELEM) > ADDR_SPAN) ||
        (RD_LAT < 1) || (ALU_LAT < 1)) begin : g_bad_cfg
        $error("matrix_seq_ctrl: matrix range exceeds address space or latency is zero");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rd_phase_c;
    logic              issue_c;
    logic [IDX_W-1:0]  issue_idx_c;
    logic              tag_vld;
    logic [IDX_W-1:0]  tag_idx;
    logic [IDX_W-1:0]  wr_next_c;
    logic [ADDR_W-1:0] rd_base_c;
    logic [ADDR_W-1:0] addr_off_c;
    logic [SEL_W-1:0]  rd_sel_c;
    logic [SEL_W-1:0]  wr_sel_c;

    // Issue decode, next addresses and element bit offsets
    always_comb begin
        rd_phase_c  = (state == RD_A) || (state == RD_B);
        issue_c     = rd_phase_c && (cnt < CNT_W'(N_ELEM));
        issue_idx_c = IDX_W'(cnt);
        rd_base_c   = (state == RD_B) ? ADDR_W'(BASE_B) : ADDR_W'(BASE_A);
        addr_off_c  = ADDR_W'(cnt) + ADDR_W'(1);
        wr_next_c   = IDX_W'(cnt) + IDX_W'(1);
        rd_sel_c    = SEL_W'(tag_idx) * SEL_W'(ELEM_W);
        wr_sel_c    = SEL_W'(wr_next_c) * SEL_W'(ELEM_W);
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (IDX_W)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_c),
        .in_idx    (issue_idx_c),
        .out_valid (tag_vld),
        .out_idx   (tag_idx)
    );

    // Sequencer FSM with registered RAM, operand and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            alu_op    <= '0;
            mat_a     <= '0;
            mat_b     <= '0;
        end else begin
            done <= 1'b0;

            // Returning read data lands in the element its tag names
            if (tag_vld) begin
                if (state == RD_A) begin
                    mat_a[rd_sel_c +: ELEM_W] <= ram_rdata;
                end else if (state == RD_B) begin
                    mat_b[rd_sel_c +: ELEM_W] <= ram_rdata;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        alu_op   <= op;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        ram_addr <= ADDR_W'(BASE_A);
                        state    <= RD_A;
                    end
                end
                RD_A, RD_B: begin
                    if (cnt == RD_LAST) begin
                        cnt <= '0;
                        if (state == RD_A) begin
                            ram_addr <= ADDR_W'(BASE_B);
                            state    <= RD_B;
                        end else begin
                            state <= EXEC;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt < ISSUE_LAST) begin
                            ram_addr <= rd_base_c + addr_off_c;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == EXEC_LAST) begin
                        cnt       <= '0;
                        ram_we    <= 1'b1;
                        ram_addr  <= ADDR_W'(BASE_C);
                        ram_wdata <= mat_c[ELEM_W-1:0];
                        state     <= WR_C;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_C: begin
                    if (cnt == WR_LAST) begin
                        cnt    <= '0;
                        ram_we <= 1'b0;
                        state  <= FIN;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        ram_addr  <= ADDR_W'(BASE_C) + addr_off_c;
                        ram_wdata <= mat_c[wr_sel_c +: ELEM_W];
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Directed bench for matrix_seq_ctrl: default build plus an RD_LAT=3 build.
`timescale 1ns/1ps
module tb_matrix_seq_ctrl;
    import matrix_pkg::*;

    localparam int unsigned EW = 8;
    localparam int unsigned NE = 25;
    localparam int unsigned AW = 8;
    localparam int unsigned MW = NE * EW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start0;
    logic          start3;
    logic [2:0]    op;
    int            fill_req;

    logic          busy0, done0, we0;
    logic [AW-1:0] addr0;
    logic [EW-1:0] wdata0, rdata0;
    logic [MW-1:0] a0, b0, c0;
    logic [2:0]    aluop0;

    logic          busy3, done3, we3;
    logic [AW-1:0] addr3;
    logic [EW-1:0] wdata3, rdata3;
    logic [MW-1:0] a3, b3, c3;
    logic [2:0]    aluop3;

    int n_assert;
    int n_fail;

    matrix_seq_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start0), .op(op), .busy(busy0), .done(done0),
        .ram_addr(addr0), .ram_wdata(wdata0), .ram_we(we0), .ram_rdata(rdata0),
        .mat_a(a0), .mat_b(b0), .alu_op(aluop0), .mat_c(c0)
    );

    matrix_seq_ctrl #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .op(op), .busy(busy3), .done(done3),
        .ram_addr(addr3), .ram_wdata(wdata3), .ram_we(we3), .ram_rdata(rdata3),
        .mat_a(a3), .mat_b(b3), .alu_op(aluop3), .mat_c(c3)
    );

    // RAM images: 1 = A k+1 / B 2k, 2 = A 255-k / B 2k, 3 = A FF / B 3k; C region EE
    function automatic logic [EW-1:0] fill_val(input int mode, input int a);
        if (a >= 64 && a < 64 + NE) return 8'hEE;
        if (a >= 32 && a < 32 + NE) return (mode == 3) ? EW'(3 * (a - 32)) : EW'(2 * (a - 32));
        if (a < NE) begin
            case (mode)
                1:       return EW'(a + 1);
                2:       return EW'(255 - a);
                default: return 8'hFF;
            endcase
        end
        return '0;
    endfunction

    // Element-wise datapath model (add, or subtract for OP_SUB)
    function automatic logic [MW-1:0] dp(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                         input logic [2:0] o);
        logic [MW-1:0] r;
        logic [EW-1:0] x, y, z;
        r = '0;
        for (int k = 0; k < NE; k++) begin
            x = EW'(a >> (k * EW));
            y = EW'(b >> (k * EW));
            z = (o == OP_SUB) ? x - y : x + y;
            r = r | (MW'(z) << (k * EW));
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] elem(input logic [MW-1:0] m, input int k);
        return EW'(m >> (k * EW));
    endfunction

    assign c0 = dp(a0, b0, aluop0);
    assign c3 = dp(a3, b3, aluop3);

    // RAM for the default build: 2-cycle read latency, counts writes
    logic [EW-1:0] ram0 [256];
    logic [EW-1:0] r0_q1, r0_q2;
    int we_cnt0 = 0;
    int bad_wr0 = 0;
    always @(posedge clk) begin
        if (fill_req != 0) begin
            for (int a = 0; a < 256; a++) ram0[8'(a)] <= fill_val(fill_req, a);
        end else if (we0) begin
            ram0[addr0] <= wdata0;
            we_cnt0 <= we_cnt0 + 1;
            if (addr0 < 8'd64 || addr0 > 8'd88) bad_wr0 <= bad_wr0 + 1;
        end
        r0_q1 <= ram0[addr0];
        r0_q2 <= r0_q1;
    end
    assign rdata0 = r0_q2;

    // RAM for the RD_LAT=3 build
    logic [EW-1:0] ram1 [256];
    logic [EW-1:0] r1_q1, r1_q2, r1_q3;
    always @(posedge clk) begin
        if (fill_req != 0) begin
            for (int a = 0; a < 256; a++) ram1[8'(a)] <= fill_val(fill_req, a);
        end else if (we3) begin
            ram1[addr3] <= wdata3;
        end
        r1_q1 <= ram1[addr3];
        r1_q2 <= r1_q1;
        r1_q3 <= r1_q2;
    end
    assign rdata3 = r1_q3;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        fill_req = mode;
        tick(1);
        fill_req = 0;
    endtask

    int err_addr, err_we, err_busy, err_done, err_mem;
    int exp_addr, we_base, bad_base, ndone, done_t, first_t, second_t;
    logic exp_we;

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 1'b1; start0 = 1'b0; start3 = 1'b0; op = OP_ADD; fill_req = 0;
        tick(3);

        // Reset state
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_we", we0, 1'b0);
        check("rst_addr", addr0, 8'd0);
        check("rst_wdata", wdata0, 8'd0);
        check("rst_alu_op", aluop0, 3'd0);
        check("rst_mat_a", a0, '0);
        check("rst_mat_b", b0, '0);
        check("rst3_busy", busy3, 1'b0);
        rst = 1'b0;

        // Run 1: add, full trace of address/we/busy/done
        fill(1);
        op = OP_ADD; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        we_base = we_cnt0; bad_base = bad_wr0;
        err_addr = 0; err_we = 0; err_busy = 0; err_done = 0;
        for (int t = 0; t <= 81; t++) begin
            exp_we = (t >= 55 && t <= 79);
            if (t <= 24)      exp_addr = t;
            else if (t <= 26) exp_addr = 24;
            else if (t <= 51) exp_addr = 32 + t - 27;
            else if (t <= 54) exp_addr = 56;
            else if (t <= 79) exp_addr = 64 + t - 55;
            else              exp_addr = 88;
            if (t <= 80) begin
                if (addr0 !== AW'(exp_addr)) err_addr++;
                if (we0 !== exp_we) err_we++;
                if (busy0 !== 1'b1) err_busy++;
                if (done0 !== 1'b0) err_done++;
            end
            if (t == 1) check("busy_after_start", busy0, 1'b1);
            if (t == 81) begin
                check("done_at_e0_81", done0, 1'b1);
                check("busy_low_at_done", busy0, 1'b0);
            end
            if (t < 81) tick(1);
        end
        check("addr_trace", err_addr, 0);
        check("we_trace", err_we, 0);
        check("busy_trace", err_busy, 0);
        check("done_early", err_done, 0);
        check("we_cycle_count", we_cnt0 - we_base, 25);
        check("writes_outside_c", bad_wr0 - bad_base, 0);
        err_mem = 0;
        for (int k = 0; k < NE; k++) if (ram0[8'(64 + k)] !== EW'(3 * k + 1)) err_mem++;
        check("c_region_values", err_mem, 0);
        check("ram64", ram0[64], 8'd1);
        check("ram88", ram0[88], 8'd73);
        tick(3);
        check("done_one_cycle", done0, 1'b0);
        check("retain_a0", elem(a0, 0), 8'd1);
        check("retain_a24", elem(a0, 24), 8'd25);
        check("retain_b24", elem(b0, 24), 8'd48);

        // Run 2: start held 5 cycles, re-pulsed mid-run with a different op
        fill(1);
        op = OP_SUB; start0 = 1'b1;
        @(posedge clk); #1;
        op = OP_SCALE;
        ndone = 0; done_t = -1;
        for (int t = 0; t <= 90; t++) begin
            if (t == 4) start0 = 1'b0;
            if (t == 39) begin start0 = 1'b1; op = OP_MUL; end
            if (t == 40) start0 = 1'b0;
            if (done0 === 1'b1) begin ndone++; done_t = t; end
            if (t == 60) check("alu_op_mid_run", aluop0, OP_SUB);
            tick(1);
        end
        check("single_done", ndone, 1);
        check("single_done_time", done_t, 81);
        check("alu_op_final", aluop0, OP_SUB);
        check("idle_after_ignored", busy0, 1'b0);

        // Run 3: reset while writing element 10 of C
        fill(1);
        op = OP_ADD; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        tick(65);
        check("we_before_rst", we0, 1'b1);
        check("addr_elem10", addr0, 8'd74);
        #1 rst = 1'b1;
        #1;
        check("rst_async_we", we0, 1'b0);
        check("rst_async_busy", busy0, 1'b0);
        check("rst_async_mat_a", a0, '0);
        tick(2);
        rst = 1'b0;
        tick(5);
        err_mem = 0;
        for (int a = 75; a <= 88; a++) if (ram0[8'(a)] !== 8'hEE) err_mem++;
        check("c_tail_untouched", err_mem, 0);
        check("c_elem9_written", ram0[73], 8'd28);
        check("idle_after_rst", busy0, 1'b0);

        // Run 4: back-to-back with new A contents between runs
        fill(1);
        op = OP_ADD; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        first_t = -1; second_t = -1;
        for (int t = 0; t <= 170; t++) begin
            if (done0 === 1'b1) begin
                if (first_t < 0) first_t = t;
                else if (second_t < 0) second_t = t;
            end
            if (t == 80) fill_req = 2;
            if (t == 81) begin fill_req = 0; start0 = 1'b1; end
            if (t == 82) start0 = 1'b0;
            tick(1);
        end
        check("b2b_first_done", first_t, 81);
        check("b2b_gap", second_t - first_t, 82);
        err_mem = 0;
        for (int k = 0; k < NE; k++) if (elem(a0, k) !== EW'(255 - k)) err_mem++;
        check("b2b_mat_a_reload", err_mem, 0);
        check("b2b_a0", elem(a0, 0), 8'hFF);
        check("b2b_ram64", ram0[64], 8'hFF);
        check("b2b_ram65", ram0[65], 8'h00);

        // Run 5: RD_LAT=3 build, tag alignment
        fill(3);
        op = OP_ADD; start3 = 1'b1;
        @(posedge clk); #1; start3 = 1'b0;
        done_t = -1;
        for (int t = 0; t <= 95; t++) begin
            if (done3 === 1'b1 && done_t < 0) done_t = t;
            tick(1);
        end
        check("lat3_done_time", done_t, 83);
        check("lat3_mat_a_ones", a3, {MW{1'b1}});
        err_mem = 0;
        for (int k = 0; k < NE; k++) if (elem(b3, k) !== EW'(3 * k)) err_mem++;
        check("lat3_mat_b_align", err_mem, 0);
        check("lat3_b1", elem(b3, 1), 8'd3);
        check("lat3_ram64", ram1[64], 8'hFF);
        check("lat3_ram88", ram1[88], 8'd71);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
